// File: rtl/adc_capture_seq_if.sv
// Capture sequencer bus: ADC sample stream and run controls in, RAM write port
// and status out. The sequencer is the master of the write bus; the
// ADC/control/RAM side is the slave.
interface adc_capture_seq_if #(
  parameter int NCH = 8,
  parameter int DW  = 16,
  parameter int AW  = 14,
  parameter int LRW = 3
);
  logic [NCH*DW-1:0] adc_data;
  logic [LRW-1:0]    log_ratio;
  logic [NCH-1:0]    chan_mask;
  logic [AW-1:0]     pre_len;
  logic [AW-1:0]     post_len;
  logic              continuous;
  logic              arm;
  logic              abort;
  logic              ack;
  logic              trig;
  logic [NCH-1:0]    wr_en;
  logic [AW-1:0]     wr_addr;
  logic [NCH*DW-1:0] wr_data;
  logic [AW-1:0]     trig_addr;
  logic [2:0]        state;
  logic              trig_missed;

  modport master (
    input  adc_data, log_ratio, chan_mask, pre_len, post_len,
    input  continuous, arm, abort, ack, trig,
    output wr_en, wr_addr, wr_data, trig_addr, state, trig_missed
  );

  modport slave (
    output adc_data, log_ratio, chan_mask, pre_len, post_len,
    output continuous, arm, abort, ack, trig,
    input  wr_en, wr_addr, wr_data, trig_addr, state, trig_missed
  );
endinterface

// File: rtl/adc_capture_seq.sv
// Multi-channel ADC capture sequencer: per-channel power-of-two boxcar
// decimation feeding a pre/post-trigger circular-buffer writer with
// single-shot or auto-rearm operation.
module adc_capture_seq #(
  parameter int NCH = 8,
  parameter int DW  = 16,
  parameter int AW  = 14,
  parameter int LRW = 3
) (
  input logic              clk,
  input logic              rst_n,
  adc_capture_seq_if.master bus
);

  localparam int ACW = DW + (1 << LRW) - 1;  // accumulator width
  localparam int CW  = (1 << LRW) - 1;       // sample counter width

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // decimator
  logic [LRW-1:0]        lr_q;
  logic [CW-1:0]         dec_cnt;
  logic [CW-1:0]         cnt_max;
  logic signed [ACW-1:0] acc_q   [NCH];
  logic signed [ACW-1:0] acc_sum [NCH];
  logic [NCH*DW-1:0]     dec_data;
  logic                  lr_chg;
  logic                  cnt_last;
  logic                  stb;

  // sequencer
  state_t            st;
  logic              trig_q;
  logic              pend;
  logic              trig_edge;
  logic              restart;
  logic              do_wr;
  logic [AW-1:0]     ptr;
  logic [AW-1:0]     pre_cnt;
  logic [AW-1:0]     post_cnt;
  logic [AW-1:0]     trig_addr_q;
  logic [AW-1:0]     wr_addr_q;
  logic [NCH-1:0]    wr_en_q;
  logic [NCH*DW-1:0] wr_data_q;
  logic              trig_missed_q;

  // Sum current sample into each accumulator and form the shifted average.
  always_comb begin
    lr_chg   = (bus.log_ratio != lr_q);
    cnt_max  = CW'((32'd1 << bus.log_ratio) - 32'd1);
    cnt_last = (dec_cnt == cnt_max);
    // a ratio change discards the sample of that cycle along with the partial sum
    stb      = !lr_chg && cnt_last;
    dec_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      acc_sum[k] = acc_q[k] + {{(ACW-DW){bus.adc_data[k*DW+DW-1]}},
                               bus.adc_data[k*DW +: DW]};
      dec_data[k*DW +: DW] = DW'(acc_sum[k] >>> bus.log_ratio);
    end
  end

  // Decimation counter and accumulators; restart on window end or ratio change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lr_q    <= '0;
      dec_cnt <= '0;
      for (int unsigned k = 0; k < NCH; k++) acc_q[k] <= '0;
    end else begin
      lr_q <= bus.log_ratio;
      if (lr_chg || cnt_last) begin
        dec_cnt <= '0;
        for (int unsigned k = 0; k < NCH; k++) acc_q[k] <= '0;
      end else begin
        dec_cnt <= dec_cnt + 1'b1;
        for (int unsigned k = 0; k < NCH; k++) acc_q[k] <= acc_sum[k];
      end
    end
  end

  // Edge detect, restart condition and write qualification.
  always_comb begin
    trig_edge = bus.trig & ~trig_q;
    restart   = bus.arm || (st == S_DONE && bus.continuous && bus.ack);
    do_wr     = stb && !bus.abort && !restart &&
                (st == S_PRE || st == S_POST ||
                 (st == S_ARMED && !(pend && bus.post_len == '0)));
  end

  // Capture FSM with registered write port and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= S_IDLE;
      trig_q        <= 1'b0;
      pend          <= 1'b0;
      ptr           <= '0;
      pre_cnt       <= '0;
      post_cnt      <= '0;
      trig_addr_q   <= '0;
      wr_addr_q     <= '0;
      wr_en_q       <= '0;
      wr_data_q     <= '0;
      trig_missed_q <= 1'b0;
    end else begin
      trig_q  <= bus.trig;
      wr_en_q <= '0;
      if (do_wr) begin
        wr_en_q   <= bus.chan_mask;
        wr_addr_q <= ptr;
        wr_data_q <= dec_data;
        ptr       <= ptr + 1'b1;
      end
      if (bus.abort) begin
        st   <= S_IDLE;
        pend <= 1'b0;
      end else if (restart) begin
        ptr           <= '0;
        pre_cnt       <= '0;
        post_cnt      <= '0;
        pend          <= 1'b0;
        trig_missed_q <= trig_edge;
        st            <= (bus.pre_len == '0) ? S_ARMED : S_PRE;
      end else begin
        if (trig_edge && st != S_ARMED) trig_missed_q <= 1'b1;
        if (trig_edge && st == S_ARMED) pend <= 1'b1;
        case (st)
          S_PRE: if (stb) begin
            pre_cnt <= pre_cnt + 1'b1;
            if (pre_cnt == bus.pre_len - 1'b1) st <= S_ARMED;
          end
          S_ARMED: if (stb && pend) begin
            trig_addr_q <= ptr;
            pend        <= 1'b0;
            if (bus.post_len == '0) begin
              st <= S_DONE;
            end else begin
              post_cnt <= AW'(1);
              st       <= (bus.post_len == AW'(1)) ? S_DONE : S_POST;
            end
          end
          S_POST: if (stb) begin
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt == bus.post_len - 1'b1) st <= S_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.trig_addr   = trig_addr_q;
  assign bus.state       = st;
  assign bus.trig_missed = trig_missed_q;

endmodule
